// File: rtl/key_load_ctrl.sv
// key_load_ctrl: serial key loader with even-parity check, fail counting and permanent lockout.
module key_load_ctrl #(
    parameter int KEY_W    = 35,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_bit,
    output logic [KEY_W-1:0] key,
    output logic             key_armed,
    output logic             busy,
    output logic             done,
    output logic             ok,
    output logic [1:0]       fail_cnt,
    output logic             locked_out
);
    localparam int CW = $clog2(KEY_W + 1);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, ARMED, LOCKOUT} state_t;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_q, par_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic [1:0]       fail_q, fail_d;
    logic             init_q;
    logic             pass;
    logic [1:0]       fail_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            key_q    <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            fail_q   <= '0;
            init_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            key_q    <= key_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            fail_q   <= fail_d;
            init_q   <= 1'b0;
        end
    end

    assign pass     = ~(^shadow_q ^ par_q);
    assign fail_inc = (fail_q == 2'(MAX_FAIL)) ? fail_q : fail_q + 2'd1;

    // init_q masks start on the first edge after reset release
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        key_d    = key_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        done_d   = 1'b0;
        ok_d     = 1'b0;
        fail_d   = fail_q;
        case (state_q)
            IDLE, ARMED: begin
                if (start && !init_q) begin
                    state_d  = LOAD;
                    shadow_d = '0;
                    cnt_d    = '0;
                end
            end
            LOAD: begin
                if (s_valid) begin
                    if (cnt_q == CW'(KEY_W)) begin
                        par_d   = s_bit;
                        state_d = CHECK;
                    end else begin
                        shadow_d[cnt_q] = s_bit;
                        cnt_d           = cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                done_d  = 1'b1;
                ok_d    = pass;
                key_d   = pass ? shadow_q : key_q;
                fail_d  = pass ? 2'd0 : fail_inc;
                state_d = pass ? ARMED : (fail_inc == 2'(MAX_FAIL)) ? LOCKOUT : IDLE;
            end
            default: state_d = state_q;
        endcase
    end

    assign s_ready    = (state_q == LOAD);
    assign busy       = (state_q == LOAD) || (state_q == CHECK);
    assign key_armed  = (state_q == ARMED);
    assign key        = key_armed ? key_q : '0;
    assign done       = done_q;
    assign ok         = ok_q;
    assign fail_cnt   = fail_q;
    assign locked_out = (state_q == LOCKOUT);
endmodule
